// File: rtl/baud_pkg.sv
// Shared constants and types for the UART baud path.
// The UART top and register file take the divisor type from here.
package baud_pkg;

  localparam int DVSR_W_DEF     = 11;
  localparam int OVERSAMPLE_DEF = 16;

  typedef logic [DVSR_W_DEF-1:0] dvsr_t;

  // Counter width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Enabled modulo counter that returns to zero once it reaches or passes a runtime terminal value.
// `at_term` is the combinational wrap condition. `wrap` is the same condition registered one clock later.
module mod_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term,
  output logic         wrap
);

  // The >= compare forces a wrap when the terminal value drops below the current count.
  assign at_term = en && (count >= term);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= at_term;
      if (at_term) begin
        count <= '0;
      end else if (en) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/baud_gen.sv
// Baud tick generator: `tick` fires every dvsr+1 clocks.
// `bit_tick` fires together with every OVERSAMPLE-th tick. Both are one-clock registered strobes.
module baud_gen
  import baud_pkg::*;
#(
  parameter int DVSR_W     = DVSR_W_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick,
  output logic              bit_tick
);

  localparam int             S_W    = cnt_width(OVERSAMPLE);
  localparam logic [S_W-1:0] S_TERM = S_W'(OVERSAMPLE - 1);

  logic [DVSR_W-1:0] r;
  logic              r_wrap;
  logic [S_W-1:0]    s;
  logic              s_at_term;

  mod_counter #(.W(DVSR_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .en      (1'b1),
    .term    (dvsr),
    .count   (r),
    .at_term (r_wrap),
    .wrap    (tick)
  );

  // The oversample counter advances on the same edge as the main wrap.
  // This keeps bit_tick aligned with the tick it belongs to.
  mod_counter #(.W(S_W)) u_ovs (
    .clk     (clk),
    .reset   (reset),
    .en      (r_wrap),
    .term    (S_TERM),
    .count   (s),
    .at_term (s_at_term),
    .wrap    (bit_tick)
  );

  a_tick_single : assert property (@(posedge clk) disable iff (!reset)
    (tick && dvsr != '0) |=> !tick);

  a_r_bounded : assert property (@(posedge clk) disable iff (!reset)
    1'b1 |=> (r <= (($past(dvsr) > $past(r)) ? $past(dvsr) : $past(r))));

  a_bit_follows : assert property (@(posedge clk) disable iff (!reset)
    s_at_term |=> bit_tick);

endmodule

// File: tb/tb_baud_gen.sv
// Randomised and directed scoreboard bench for baud_gen against a per-edge model of the tick rules.
module tb_baud_gen;

  localparam int DW  = 11;
  localparam int OVS = 16;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] dvsr  = 11'd3;
  logic          tick;
  logic          bit_tick;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];   // {bit_tick, tick} expected after each edge
  logic [1:0] last_exp = 2'b00;

  // Reference model: clocks elapsed since the last wrap, and ticks issued since reset.
  int elapsed = 0;
  int ticks   = 0;

  always #5 clk = ~clk;

  baud_gen #(.DVSR_W(DW), .OVERSAMPLE(OVS)) dut (
    .clk      (clk),
    .reset    (reset),
    .dvsr     (dvsr),
    .tick     (tick),
    .bit_tick (bit_tick)
  );

  task automatic model_step(input logic [DW-1:0] d, input logic rst);
    logic w, b;
    if (!rst) begin
      elapsed  = 0;
      ticks    = 0;
      last_exp = 2'b00;
    end else begin
      w = (elapsed >= int'(d));
      b = w && ((ticks % OVS) == OVS - 1);
      last_exp = {b, w};
      if (w) begin
        elapsed = 0;
        ticks++;
      end else begin
        elapsed++;
      end
    end
    exp_q.push_back(last_exp);
  endtask

  task automatic cycle(input logic [DW-1:0] d, input logic rst);
    @(negedge clk);
    dvsr  = d;
    reset = rst;
    model_step(d, rst);
  endtask

  // Like cycle, but first checks the counter value present between edges.
  task automatic cycle_chk_r(input logic [DW-1:0] d, input logic rst, input int exp_r);
    @(negedge clk);
    checks++;
    if (int'(dut.r) != exp_r) begin
      errors++;
      $display("FAIL r_before_change t=%0t got r=%0d exp r=%0d", $time, dut.r, exp_r);
    end
    dvsr  = d;
    reset = rst;
    model_step(d, rst);
  endtask

  task automatic run(input logic [DW-1:0] d, input int n);
    repeat (n) cycle(d, 1'b1);
  endtask

  task automatic run_until_r(input logic [DW-1:0] d, input int target);
    int n = 0;
    while (elapsed != target && n < 5000) begin
      cycle(d, 1'b1);
      n++;
    end
    if (elapsed != target) begin
      checks++;
      errors++;
      $display("FAIL timeout_r t=%0t waited for r=%0d", $time, target);
    end
  endtask

  task automatic check_cleared(input string name);
    #1;
    checks++;
    if (tick !== 1'b0 || bit_tick !== 1'b0 || dut.r !== '0) begin
      errors++;
      $display("FAIL %s t=%0t got tick=%b bit_tick=%b r=%0d exp all 0",
               name, $time, tick, bit_tick, dut.r);
    end
  endtask

  // Monitor: a fresh output pair appears every clock, shortly after the rising edge.
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bit_tick, tick} !== e) begin
          errors++;
          $display("FAIL sb_cycle t=%0t got tick=%b bit_tick=%b exp tick=%b bit_tick=%b",
                   $time, tick, bit_tick, e[0], e[1]);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    int n;

    #2;
    checks++;
    if (tick !== 1'b0 || bit_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got tick=%b bit_tick=%b exp 0 0", tick, bit_tick);
    end

    // Reset while running, then the bit strobe with dvsr=3.
    repeat (3) cycle(11'd3, 1'b0);
    run(11'd3, 10);
    repeat (10) cycle(11'd3, 1'b0);
    run(11'd3, 300);

    // dvsr = 0 gives a continuous tick.
    run(11'd0, 100);

    // Mid-count changes: 10 -> 5 at r=8, then 5 -> 20 at r=2.
    run_until_r(11'd10, 0);
    run_until_r(11'd10, 8);
    cycle_chk_r(11'd5, 1'b1, 8);
    run(11'd5, 30);
    run_until_r(11'd5, 2);
    cycle_chk_r(11'd20, 1'b1, 2);
    run(11'd20, 60);

    // Maximum divisor.
    run(11'd2047, 4200);

    // Asynchronous reset between edges with r=2.
    run_until_r(11'd3, 2);
    cycle_chk_r(11'd3, 1'b0, 2);
    check_cleared("async_reset_mid");
    cycle(11'd3, 1'b0);
    run(11'd3, 50);

    // Asynchronous reset while tick and bit_tick are both high.
    n = 0;
    while (last_exp != 2'b11 && n < 200) begin
      cycle(11'd0, 1'b1);
      n++;
    end
    if (last_exp != 2'b11) begin
      checks++;
      errors++;
      $display("FAIL timeout_bit_tick t=%0t", $time);
    end
    cycle(11'd0, 1'b0);
    check_cleared("async_reset_strobe");
    cycle(11'd0, 1'b0);

    // Random divisors, random mid-count changes and occasional resets.
    d = 11'd7;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) d = DW'($urandom_range(0, 40));
      if ($urandom_range(0, 199) == 0) cycle(d, 1'b0);
      else cycle(d, 1'b1);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
